// File: rtl/ps_gate_pkg.sv
// Shared types for the PacketStream traffic gate.
package ps_gate_pkg;

  // Per-lane packet position: boundary, forwarding, or swallowing a dropped packet.
  typedef enum logic [1:0] {
    StSop     = 2'd0,
    StPass    = 2'd1,
    StDiscard = 2'd2
  } lane_state_e;

endpackage

// File: rtl/ps_gate_lane.sv
// One gate lane: boundary-aware open/close FSM, data gating and drop counter.
module ps_gate_lane
  import ps_gate_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             turnoff,
  input  logic             dropmode,
  input  logic             cnt_clr,
  output logic             busy,
  output logic [CNTW-1:0]  drop_cnt,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_val,
  input  logic             i_eop,
  output logic             i_rdy,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_val,
  output logic             o_eop,
  input  logic             o_rdy
);

  lane_state_e     state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            drop_inc;

  assign o_dat    = i_dat;
  assign busy     = (state_q != StSop);
  assign drop_cnt = cnt_q;

  // Gating and next state; turnoff/dropmode are only looked at on a boundary.
  always_comb begin
    o_val    = 1'b0;
    o_eop    = 1'b0;
    i_rdy    = 1'b0;
    drop_inc = 1'b0;
    state_d  = state_q;
    unique case (state_q)
      StSop: begin
        if (!turnoff) begin
          o_val = i_val;
          o_eop = i_eop;
          i_rdy = o_rdy;
          if (i_val && o_rdy && !i_eop) state_d = StPass;
        end else if (dropmode) begin
          // Drop mode never looks at o_rdy, so no o_rdy->i_rdy path here.
          i_rdy = 1'b1;
          if (i_val) begin
            drop_inc = 1'b1;
            if (!i_eop) state_d = StDiscard;
          end
        end
      end
      StPass: begin
        o_val = i_val;
        o_eop = i_eop;
        i_rdy = o_rdy;
        if (i_val && o_rdy && i_eop) state_d = StSop;
      end
      StDiscard: begin
        i_rdy = 1'b1;
        if (i_val && i_eop) state_d = StSop;
      end
      default: state_d = StSop;
    endcase
  end

  // Saturating drop count; a clear coinciding with a drop leaves exactly that drop.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = drop_inc ? CNTW'(1) : '0;
    end else if (drop_inc && (cnt_q != {CNTW{1'b1}})) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StSop;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/ps_gate_mc.sv
// Multi-channel packet-aware gate: CHANNELS independent ps_gate_lane instances.
module ps_gate_mc
  import ps_gate_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNTW     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       turnoff,
  input  logic [CHANNELS-1:0]       dropmode,
  input  logic [CHANNELS-1:0]       cnt_clr,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS*CNTW-1:0]  drop_cnt,
  input  logic [CHANNELS*WIDTH-1:0] i_dat,
  input  logic [CHANNELS-1:0]       i_val,
  input  logic [CHANNELS-1:0]       i_eop,
  output logic [CHANNELS-1:0]       i_rdy,
  output logic [CHANNELS*WIDTH-1:0] o_dat,
  output logic [CHANNELS-1:0]       o_val,
  output logic [CHANNELS-1:0]       o_eop,
  input  logic [CHANNELS-1:0]       o_rdy
);

  // One lane per channel; lanes share nothing but clock and reset.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    ps_gate_lane #(
      .WIDTH (WIDTH),
      .CNTW  (CNTW)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .turnoff  (turnoff[k]),
      .dropmode (dropmode[k]),
      .cnt_clr  (cnt_clr[k]),
      .busy     (busy[k]),
      .drop_cnt (drop_cnt[k*CNTW +: CNTW]),
      .i_dat    (i_dat[k*WIDTH +: WIDTH]),
      .i_val    (i_val[k]),
      .i_eop    (i_eop[k]),
      .i_rdy    (i_rdy[k]),
      .o_dat    (o_dat[k*WIDTH +: WIDTH]),
      .o_val    (o_val[k]),
      .o_eop    (o_eop[k]),
      .o_rdy    (o_rdy[k])
    );
  end

endmodule

// File: tb/tb_ps_gate_mc.sv
// Bench for ps_gate_mc: per-lane reference model plus forwarded-word scoreboard.
module tb_ps_gate_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  turnoff, dropmode, cnt_clr, busy, i_val, i_eop, i_rdy, o_val, o_eop, o_rdy;
  logic [63:0] drop_cnt;
  logic [31:0] i_dat, o_dat;

  // Narrow-counter instance for saturation checks.
  logic        s_toff, s_dm, s_clr, s_busy, s_val, s_eop, s_irdy, s_oval, s_oeop, s_ordy;
  logic [1:0]  s_cnt;
  logic [7:0]  s_idat, s_odat;

  int checks = 0;
  int errors = 0;
  int ms [4];
  int mc [4];
  int beats [4];
  logic [8:0] sbq [4][$];

  always #5 clk = ~clk;

  ps_gate_mc #(.WIDTH(8), .CHANNELS(4), .CNTW(16)) dut (
    .clk(clk), .reset(reset), .turnoff(turnoff), .dropmode(dropmode), .cnt_clr(cnt_clr),
    .busy(busy), .drop_cnt(drop_cnt), .i_dat(i_dat), .i_val(i_val), .i_eop(i_eop),
    .i_rdy(i_rdy), .o_dat(o_dat), .o_val(o_val), .o_eop(o_eop), .o_rdy(o_rdy)
  );

  ps_gate_mc #(.WIDTH(8), .CHANNELS(1), .CNTW(2)) dut_sat (
    .clk(clk), .reset(reset), .turnoff(s_toff), .dropmode(s_dm), .cnt_clr(s_clr),
    .busy(s_busy), .drop_cnt(s_cnt), .i_dat(s_idat), .i_val(s_val), .i_eop(s_eop),
    .i_rdy(s_irdy), .o_dat(s_odat), .o_val(s_oval), .o_eop(s_oeop), .o_rdy(s_ordy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      ms[k] = 0;
      mc[k] = 0;
    end
  endtask

  // Compare one lane against the model mid-cycle, then advance the model.
  task automatic eval_lane(input int k);
    logic pass, disc, exp_irdy, first, xfer;
    logic [8:0] e;
    pass     = (ms[k] == 1) || (ms[k] == 0 && !turnoff[k]);
    disc     = !pass && ((ms[k] == 2) || dropmode[k]);
    exp_irdy = pass ? o_rdy[k] : disc;
    chk($sformatf("busy[%0d]", k), 64'(busy[k]), 64'(ms[k] != 0));
    chk($sformatf("drop_cnt[%0d]", k), 64'(drop_cnt[k*16 +: 16]), 64'(mc[k]));
    chk($sformatf("i_rdy[%0d]", k), 64'(i_rdy[k]), 64'(exp_irdy));
    chk($sformatf("o_val[%0d]", k), 64'(o_val[k]), 64'(pass & i_val[k]));
    chk($sformatf("o_dat[%0d]", k), 64'(o_dat[k*8 +: 8]), 64'(i_dat[k*8 +: 8]));
    if (pass && i_val[k] && o_rdy[k]) sbq[k].push_back({i_eop[k], i_dat[k*8 +: 8]});
    if (o_val[k] && o_rdy[k]) begin
      if (sbq[k].size() == 0) begin
        chk($sformatf("sb_underflow[%0d]", k), 64'(sbq[k].size()), 64'd1);
      end else begin
        e = sbq[k].pop_front();
        chk($sformatf("sb_word[%0d]", k), {55'd0, o_eop[k], o_dat[k*8 +: 8]}, 64'(e));
        beats[k]++;
      end
    end
    xfer  = i_val[k] && exp_irdy;
    first = xfer && (ms[k] == 0) && disc;
    if (cnt_clr[k]) mc[k] = first ? 1 : 0;
    else if (first && mc[k] < 65535) mc[k]++;
    if (xfer) ms[k] = i_eop[k] ? 0 : (pass ? 1 : 2);
  endtask

  task automatic cyc();
    @(negedge clk);
    if (reset) model_reset();
    for (int k = 0; k < 4; k++) eval_lane(k);
    @(posedge clk);
    #1;
    if (reset) model_reset();
  endtask

  task automatic idle();
    turnoff = '0; dropmode = '0; cnt_clr = '0; i_val = '0; i_eop = '0; i_dat = '0;
    o_rdy = 4'hF;
  endtask

  task automatic drive(input int k, input logic v, input logic eop, input logic [7:0] d);
    i_val[k] = v;
    i_eop[k] = eop;
    i_dat[k*8 +: 8] = d;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    s_toff = 1'b1; s_dm = 1'b1; s_clr = 1'b0; s_val = 1'b0; s_eop = 1'b0; s_idat = '0;
    s_ordy = 1'b0;
    model_reset();
    for (int k = 0; k < 4; k++) beats[k] = 0;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();

    // Lane 0: 4-word packet, gate open.
    for (int w = 0; w < 4; w++) begin
      drive(0, 1'b1, w == 3, 8'hA0 + 8'(w));
      cyc();
    end
    drive(0, 1'b0, 1'b0, 8'h00);
    cyc();
    chk("l0_beats", 64'(beats[0]), 64'd4);
    chk("l0_cnt", 64'(drop_cnt[15:0]), 64'd0);

    // Lane 1: turnoff mid-packet is ignored; next packet held until turnoff drops.
    for (int w = 0; w < 3; w++) begin
      turnoff[1] = (w >= 1);
      drive(1, 1'b1, w == 2, 8'hB0 + 8'(w));
      cyc();
    end
    chk("l1_pkt1_beats", 64'(beats[1]), 64'd3);
    for (int w = 0; w < 3; w++) begin
      drive(1, 1'b1, 1'b0, 8'hC0);
      cyc();
      chk("l1_held_rdy", 64'(i_rdy[1]), 64'd0);
    end
    turnoff[1] = 1'b0;
    cyc();
    drive(1, 1'b1, 1'b1, 8'hC1);
    cyc();
    drive(1, 1'b0, 1'b0, 8'h00);
    cyc();
    chk("l1_pkt2_beats", 64'(beats[1]), 64'd5);

    // Lane 2: drop five 3-word packets with the sink stalled.
    turnoff[2] = 1'b1; dropmode[2] = 1'b1; o_rdy[2] = 1'b0;
    for (int p = 0; p < 5; p++) begin
      for (int w = 0; w < 3; w++) begin
        drive(2, 1'b1, w == 2, 8'(16 * p + w));
        cyc();
      end
    end
    drive(2, 1'b0, 1'b0, 8'h00);
    cyc();
    chk("l2_cnt5", 64'(drop_cnt[47:32]), 64'd5);
    chk("l2_beats", 64'(beats[2]), 64'd0);
    drive(2, 1'b1, 1'b1, 8'h55);
    cyc();
    chk("l2_cnt6", 64'(drop_cnt[47:32]), 64'd6);
    chk("l2_busy", 64'(busy[2]), 64'd0);
    idle();

    // 2-bit counter saturates at 3; clear with a new drop leaves 1.
    for (int p = 0; p < 5; p++) begin
      s_val = 1'b1; s_eop = 1'b0;
      cyc();
      s_eop = 1'b1;
      cyc();
      chk($sformatf("sat_cnt_p%0d", p), 64'(s_cnt), 64'(p < 3 ? p + 1 : 3));
    end
    s_clr = 1'b1; s_eop = 1'b1;
    cyc();
    s_clr = 1'b0; s_val = 1'b0;
    chk("sat_clr_inc", 64'(s_cnt), 64'd1);
    chk("sat_busy", 64'(s_busy), 64'd0);

    // Lane 3: reset while discarding; the rest of the packet then passes.
    turnoff[3] = 1'b1; dropmode[3] = 1'b1;
    drive(3, 1'b1, 1'b0, 8'h30);
    cyc();
    chk("l3_disc_busy", 64'(busy[3]), 64'd1);
    chk("l3_disc_cnt", 64'(drop_cnt[63:48]), 64'd1);
    reset = 1'b1;
    drive(3, 1'b0, 1'b0, 8'h00);
    cyc();
    reset = 1'b0;
    chk("l3_rst_busy", 64'(busy[3]), 64'd0);
    chk("l3_rst_cnt", 64'(drop_cnt[63:48]), 64'd0);
    turnoff[3] = 1'b0;
    drive(3, 1'b1, 1'b0, 8'h31);
    cyc();
    drive(3, 1'b1, 1'b1, 8'h32);
    cyc();
    drive(3, 1'b0, 1'b0, 8'h00);
    cyc();
    chk("l3_beats", 64'(beats[3]), 64'd2);

    // All lanes concurrently with random traffic and control toggling.
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 4; k++) begin
        drive(k, 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, 8'($urandom));
        o_rdy[k] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) turnoff[k] = ~turnoff[k];
        if ($urandom_range(0, 3) == 0) dropmode[k] = ~dropmode[k];
        cnt_clr[k] = ($urandom_range(0, 15) == 0);
      end
      cyc();
    end
    idle();
    cyc();
    for (int k = 0; k < 4; k++) chk($sformatf("sb_left[%0d]", k), 64'(sbq[k].size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
